qpsk_mapper: RTL and testbench

- QPSK/4-QAM Gray symbol mapper with zero-insertion upsampler; sits directly downstream of the 2-bit serial-to-parallel stage in the QAM transmitter.
- Tracks bit-pair phase from the shared bit strobe `en`, captures each completed 2-bit symbol, and maps it to signed I/Q levels.
- Emits OSR samples per symbol (one symbol sample, then OSR-1 zeros) toward the pulse-shaping filter.
- Has a 1-deep holding buffer and a sticky overflow flag.

---
 rtl/qam_pkg.sv | 31 +++
 rtl/qpsk_mapper_if.sv | 31 +++
 rtl/qpsk_upsampler.sv | 136 +++++++++++++
 rtl/qpsk_mapper.sv | 75 +++++++
 tb/tb_qpsk_mapper.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/qam_pkg.sv
// qam_pkg: shared types and helpers for the QAM transmitter datapath.
//   SYM_W     - bits per QPSK symbol
//   state_t   - burst FSM states {IDLE, BURST}
//   iq_t      - raw 32-bit I/Q pair returned by map_qpsk
//   map_qpsk  - Gray mapping of a 2-bit symbol to +/-amp, truncated to width bits
package qam_pkg;

  localparam int SYM_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] q;
  } iq_t;

  // Bit 1 selects the I sign, bit 0 the Q sign; a set bit means negative.
  // Results are masked to width bits so callers can slice the low bits directly.
  function automatic iq_t map_qpsk(input logic [SYM_W-1:0] sym, input int amp, input int width);
    iq_t r;
    int  mask;
    mask = (width >= 32) ? -1 : ((1 << width) - 1);
    r.i  = (sym[1] ? -amp : amp) & mask;
    r.q  = (sym[0] ? -amp : amp) & mask;
    return r;
  endfunction

endpackage

// File: rtl/qpsk_mapper_if.sv
// qpsk_mapper_if: symbol-in / sample-out bundle of the QPSK mapper.
//   en        - bit strobe shared with the upstream S/P stage
//   sym_in    - parallel symbol, [1] first serial bit
//   out_valid - I/Q sample valid
//   out_i/q   - signed WIDTH-bit samples
//   out_sos   - start of symbol (non-zero sample of a burst)
//   ovf       - sticky dropped-symbol flag
// master drives en/sym_in; slave (the mapper) drives the outputs.
interface qpsk_mapper_if
  import qam_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic                    en;
  logic        [SYM_W-1:0] sym_in;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_i;
  logic signed [WIDTH-1:0] out_q;
  logic                    out_sos;
  logic                    ovf;

  modport master (
    output en, sym_in,
    input  out_valid, out_i, out_q, out_sos, ovf
  );

  modport slave (
    input  en, sym_in,
    output out_valid, out_i, out_q, out_sos, ovf
  );
endinterface

// File: rtl/qpsk_upsampler.sv
// qpsk_upsampler: burst generator for the QPSK mapper. Each started symbol yields OSR
// output samples: the mapped I/Q first (o_sos high), then OSR-1 zeros, or repeats of the
// I/Q when QPSK_MAPPER_HOLD_EN is defined. A symbol arriving mid-burst is held in a
// 1-deep buffer; one arriving while the buffer is full is dropped and sets o_ovf (sticky).
//   clk, rst      - clock, asynchronous active-high reset
//   i_start       - symbol capture strobe, i_i/i_q carry its mapped levels
//   o_valid       - sample valid
//   o_i, o_q      - registered samples
//   o_sos         - start-of-symbol
//   o_ovf         - sticky overflow
module qpsk_upsampler
  import qam_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OSR   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic signed [WIDTH-1:0] i_i,
  input  logic signed [WIDTH-1:0] i_q,
  output logic                    o_valid,
  output logic signed [WIDTH-1:0] o_i,
  output logic signed [WIDTH-1:0] o_q,
  output logic                    o_sos,
  output logic                    o_ovf
);

  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0] LAST = CW'(OSR - 1);

  state_t                  r_state, w_state_nxt;
  logic        [CW-1:0]    r_cnt, w_cnt_nxt;
  logic                    r_buf_full, w_buf_full_nxt;
  logic signed [WIDTH-1:0] r_buf_i, w_buf_i_nxt;
  logic signed [WIDTH-1:0] r_buf_q, w_buf_q_nxt;
  logic                    r_ovf, w_ovf_nxt;
  logic                    r_valid, w_valid_nxt;
  logic                    r_sos, w_sos_nxt;
  logic signed [WIDTH-1:0] r_i, w_i_nxt;
  logic signed [WIDTH-1:0] r_q, w_q_nxt;
  logic                    w_handoff;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_buf_full_nxt = r_buf_full;
    w_buf_i_nxt    = r_buf_i;
    w_buf_q_nxt    = r_buf_q;
    w_ovf_nxt      = r_ovf;
    w_valid_nxt    = 1'b0;
    w_sos_nxt      = 1'b0;
    w_i_nxt        = '0;
    w_q_nxt        = '0;
    // IDLE behaves like the handoff of an empty buffer; the buffer is never full in IDLE.
    w_handoff      = (r_state == IDLE) || (r_cnt == LAST);

    if (w_handoff) begin
      if (r_buf_full || i_start) begin
        w_valid_nxt = 1'b1;
        w_sos_nxt   = 1'b1;
        w_cnt_nxt   = '0;
        if (OSR > 1) begin
          w_state_nxt = BURST;
        end else begin
          w_state_nxt = IDLE;
        end
        if (r_buf_full) begin
          // Buffered symbol goes first; a simultaneous capture refills the buffer.
          w_i_nxt        = r_buf_i;
          w_q_nxt        = r_buf_q;
          w_buf_full_nxt = i_start;
          if (i_start) begin
            w_buf_i_nxt = i_i;
            w_buf_q_nxt = i_q;
          end
        end else begin
          w_i_nxt = i_i;
          w_q_nxt = i_q;
        end
      end else begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    end else begin
      w_cnt_nxt   = r_cnt + CW'(1);
      w_valid_nxt = 1'b1;
`ifdef QPSK_MAPPER_HOLD_EN
      w_i_nxt     = r_i;
      w_q_nxt     = r_q;
`endif
      if (i_start) begin
        if (r_buf_full) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_buf_full_nxt = 1'b1;
          w_buf_i_nxt    = i_i;
          w_buf_q_nxt    = i_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_buf_full <= 1'b0;
      r_buf_i    <= '0;
      r_buf_q    <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
      r_sos      <= 1'b0;
      r_i        <= '0;
      r_q        <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_buf_full <= w_buf_full_nxt;
      r_buf_i    <= w_buf_i_nxt;
      r_buf_q    <= w_buf_q_nxt;
      r_ovf      <= w_ovf_nxt;
      r_valid    <= w_valid_nxt;
      r_sos      <= w_sos_nxt;
      r_i        <= w_i_nxt;
      r_q        <= w_q_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_i     = r_i;
  assign o_q     = r_q;
  assign o_sos   = r_sos;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/qpsk_mapper.sv
// qpsk_mapper: QPSK Gray mapper with OSR-times upsampling, placed after the 2-bit S/P stage.
// Tracks the bit-pair phase from the shared strobe en, captures each completed symbol one
// edge after its second bit, maps it to +/-AMP and hands it to qpsk_upsampler.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - qpsk_mapper_if slave: en/sym_in in; out_valid/out_i/out_q/out_sos/ovf out
// Build option: define QPSK_MAPPER_HOLD_EN for sample-and-hold instead of zero insertion.
module qpsk_mapper
  import qam_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMP   = 64,
  parameter int OSR   = 2
) (
  input  logic          clk,
  input  logic          rst,
  qpsk_mapper_if.slave  bus
);

  logic                    r_phase;
  logic                    r_sym_rdy;
  iq_t                     w_iq;
  logic signed [WIDTH-1:0] w_i;
  logic signed [WIDTH-1:0] w_q;
  logic                    w_valid;
  logic signed [WIDTH-1:0] w_out_i;
  logic signed [WIDTH-1:0] w_out_q;
  logic                    w_sos;
  logic                    w_ovf;

  // r_phase mirrors the upstream swap register; r_sym_rdy pulses one edge after the
  // second bit of a pair, when sym_in has become valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase   <= 1'b0;
      r_sym_rdy <= 1'b0;
    end else begin
      if (bus.en) begin
        r_phase <= ~r_phase;
      end
      r_sym_rdy <= bus.en & r_phase;
    end
  end

  assign w_iq = map_qpsk(bus.sym_in, AMP, WIDTH);
  assign w_i  = w_iq.i[WIDTH-1:0];
  assign w_q  = w_iq.q[WIDTH-1:0];

  if (WIDTH < 32) begin : g_iq_upper
    logic w_unused_iq;
    assign w_unused_iq = ^{w_iq.i[31:WIDTH], w_iq.q[31:WIDTH]};
  end

  qpsk_upsampler #(
    .WIDTH (WIDTH),
    .OSR   (OSR)
  ) u_upsampler (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_sym_rdy),
    .i_i     (w_i),
    .i_q     (w_q),
    .o_valid (w_valid),
    .o_i     (w_out_i),
    .o_q     (w_out_q),
    .o_sos   (w_sos),
    .o_ovf   (w_ovf)
  );

  assign bus.out_valid = w_valid;
  assign bus.out_i     = w_out_i;
  assign bus.out_q     = w_out_q;
  assign bus.out_sos   = w_sos;
  assign bus.ovf       = w_ovf;

endmodule

// File: tb/tb_qpsk_mapper.sv
// tb_qpsk_mapper: directed bench for qpsk_mapper, WIDTH=8, AMP=64, with one OSR=2 and one
// OSR=4 instance sharing clk/rst/en/sym_in. Observed tuple per cycle is
// {out_valid, out_sos, out_i, out_q}. Expectations follow QPSK_MAPPER_HOLD_EN if defined.
module tb_qpsk_mapper;

`ifdef QPSK_MAPPER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] sym_in = 2'b00;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  qpsk_mapper_if #(.WIDTH(8)) if2 ();
  qpsk_mapper_if #(.WIDTH(8)) if4 ();

  assign if2.en     = en;
  assign if2.sym_in = sym_in;
  assign if4.en     = en;
  assign if4.sym_in = sym_in;

  qpsk_mapper #(.WIDTH(8), .AMP(64), .OSR(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  qpsk_mapper #(.WIDTH(8), .AMP(64), .OSR(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  function automatic logic [17:0] obs2();
    return {if2.out_valid, if2.out_sos, if2.out_i, if2.out_q};
  endfunction

  function automatic logic [17:0] obs4();
    return {if4.out_valid, if4.out_sos, if4.out_i, if4.out_q};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    sym_in = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (obs2() !== 18'h0) begin
      n_err++; $display("FAIL reset_out2: got %h want %h", obs2(), 18'h0);
    end
    n_vec++;
    if (obs4() !== 18'h0) begin
      n_err++; $display("FAIL reset_out4: got %h want %h", obs4(), 18'h0);
    end
    n_vec++;
    if ({if2.ovf, if4.ovf} !== 2'b00) begin
      n_err++; $display("FAIL reset_ovf: got %b want 00", {if2.ovf, if4.ovf});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({if2.out_valid, if4.out_valid} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle: got %b want 00", {if2.out_valid, if4.out_valid});
    end
  endtask

  // Pair 00 on OSR=2: symbol after the 3rd edge, zero after the 4th, idle after the 5th.
  task automatic test_single();
    logic [17:0] exp;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      if (n == 2) en = 1'b0;
      if (n >= 3) begin
        if (n == 3)      exp = {2'b11, 8'h40, 8'h40};
        else if (n == 4) exp = {2'b10, HOLD ? 8'h40 : 8'h00, HOLD ? 8'h40 : 8'h00};
        else             exp = 18'h0;
        n_vec++;
        if (obs2() !== exp) begin
          n_err++; $display("FAIL single[%0d]: got %h want %h", n, obs2(), exp);
        end
      end
    end
  endtask

  // 00,01,11,10 on continuous en, OSR=2: gapless bursts.
  task automatic test_stream();
    logic [1:0]  syms [4];
    logic [7:0]  si   [4];
    logic [7:0]  sq   [4];
    logic [17:0] exp;
    int          idx;
    syms = '{2'b00, 2'b01, 2'b11, 2'b10};
    si   = '{8'h40, 8'h40, 8'hC0, 8'hC0};
    sq   = '{8'h40, 8'hC0, 8'hC0, 8'h40};
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (n >= 3) begin
        idx = n - 3;
        if (n == 11)          exp = 18'h0;
        else if (idx % 2 == 0) exp = {2'b11, si[idx/2], sq[idx/2]};
        else exp = {2'b10, HOLD ? si[idx/2] : 8'h00, HOLD ? sq[idx/2] : 8'h00};
        n_vec++;
        if (obs2() !== exp) begin
          n_err++; $display("FAIL stream[%0d]: got %h want %h", n, obs2(), exp);
        end
      end
      if (n % 2 == 0 && n <= 8) sym_in = syms[n/2-1];
      if (n == 8) en = 1'b0;
    end
    n_vec++;
    if (if2.ovf !== 1'b0) begin
      n_err++; $display("FAIL stream_ovf: got %b want 0", if2.ovf);
    end
  endtask

  // OSR=4, four back-to-back pairs: 2nd buffered, 3rd buffered at handoff, 4th dropped.
  task automatic test_back_to_back_ovf();
    logic [1:0]  syms [4];
    logic [7:0]  si   [3];
    logic [7:0]  sq   [3];
    logic [17:0] exp;
    logic        exp_ovf;
    int          idx;
    syms = '{2'b00, 2'b11, 2'b01, 2'b10};
    si   = '{8'h40, 8'hC0, 8'h40};
    sq   = '{8'h40, 8'hC0, 8'hC0};
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (n >= 3) begin
        idx = n - 3;
        if (n == 15)           exp = 18'h0;
        else if (idx % 4 == 0) exp = {2'b11, si[idx/4], sq[idx/4]};
        else exp = {2'b10, HOLD ? si[idx/4] : 8'h00, HOLD ? sq[idx/4] : 8'h00};
        n_vec++;
        if (obs4() !== exp) begin
          n_err++; $display("FAIL b2b[%0d]: got %h want %h", n, obs4(), exp);
        end
        exp_ovf = (n >= 9);
        n_vec++;
        if (if4.ovf !== exp_ovf) begin
          n_err++; $display("FAIL b2b_ovf[%0d]: got %b want %b", n, if4.ovf, exp_ovf);
        end
      end
      if (n % 2 == 0 && n <= 8) sym_in = syms[n/2-1];
      if (n == 8) en = 1'b0;
    end
    for (int n = 0; n < 5; n++) tick();
    n_vec++;
    if (if4.ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky: got %b want 1", if4.ovf);
    end
  endtask

  // One bit, five idle cycles, second bit; symbol 10 -> (-64,+64).
  task automatic test_irregular_en();
    logic [17:0] exp;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n <= 7)      exp = 18'h0;
      else if (n == 8) exp = {2'b11, 8'hC0, 8'h40};
      else if (n == 9) exp = {2'b10, HOLD ? 8'hC0 : 8'h00, HOLD ? 8'h40 : 8'h00};
      else             exp = 18'h0;
      n_vec++;
      if (obs2() !== exp) begin
        n_err++; $display("FAIL irregular[%0d]: got %h want %h", n, obs2(), exp);
      end
      if (n == 1) en = 1'b0;
      if (n == 6) en = 1'b1;
      if (n == 7) begin
        en = 1'b0;
        sym_in = 2'b10;
      end
    end
  endtask

  // Reset at cnt=2 of an OSR=4 burst with the phase left at 1; next pair must align at 0.
  task automatic test_rst_mid_burst();
    logic [17:0] exp;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      if (n == 2) sym_in = 2'b11;
      if (n == 3) en = 1'b0;
    end
    exp = {2'b10, HOLD ? 8'hC0 : 8'h00, HOLD ? 8'hC0 : 8'h00};
    n_vec++;
    if (obs4() !== exp) begin
      n_err++; $display("FAIL pre_rst: got %h want %h", obs4(), exp);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({obs4(), if4.ovf} !== 19'h0) begin
      n_err++; $display("FAIL rst_async: got %h want %h", {obs4(), if4.ovf}, 19'h0);
    end
    tick();
    rst = 1'b0;
    en = 1'b1;
    sym_in = 2'b00;
    for (int m = 1; m <= 4; m++) begin
      tick();
      if (m <= 2)      exp = 18'h0;
      else if (m == 3) exp = {2'b11, 8'h40, 8'hC0};
      else             exp = {2'b10, HOLD ? 8'h40 : 8'h00, HOLD ? 8'hC0 : 8'h00};
      n_vec++;
      if (obs4() !== exp) begin
        n_err++; $display("FAIL post_rst[%0d]: got %h want %h", m, obs4(), exp);
      end
      if (m == 2) begin
        sym_in = 2'b01;
        en = 1'b0;
      end
    end
  endtask

  // Symbol 11 on OSR=4: four samples, first with sos; held levels or zeros per build.
  task automatic test_upsample_osr4();
    logic [17:0] exp;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 3)                exp = {2'b11, 8'hC0, 8'hC0};
      else if (n > 3 && n <= 6)  exp = {2'b10, HOLD ? 8'hC0 : 8'h00, HOLD ? 8'hC0 : 8'h00};
      else                       exp = 18'h0;
      if (n >= 2) begin
        n_vec++;
        if (obs4() !== exp) begin
          n_err++; $display("FAIL osr4[%0d]: got %h want %h", n, obs4(), exp);
        end
      end
      if (n == 2) begin
        sym_in = 2'b11;
        en = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_back_to_back_ovf();
    test_irregular_en();
    test_rst_mid_burst();
    test_upsample_osr4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
